// File: rtl/adc_mon_pkg.sv
// Shared types and defaults for the ADC level monitor.
package adc_mon_pkg;

    // Debounce FSM encoding; values are visible on debug taps, so keep them fixed.
    typedef enum logic [1:0] {
        LOW     = 2'd0,
        RISING  = 2'd1,
        HIGH    = 2'd2,
        FALLING = 2'd3
    } level_state_t;

    localparam int          SAMPLE_DIV_DEF = 50000;
    localparam int          AVG_LOG2_DEF   = 4;
    localparam int          HOLD_CNT_DEF   = 8;
    localparam logic [7:0]  TH_HIGH_DEF    = 8'd180;
    localparam logic [7:0]  TH_LOW_DEF     = 8'd120;

endpackage

// File: rtl/adc_level_monitor_if.sv
// Sample-in / level-out bundle between the ADC capture stage and the monitor.
interface adc_level_monitor_if;

    logic [7:0] i_adc_data;
    logic       i_enable;
    logic [7:0] o_avg;
    logic       o_avg_valid;
    logic       o_level_high;
    logic       o_event;

    // Producer side: supplies samples and enable, observes results.
    modport master (
        output i_adc_data,
        output i_enable,
        input  o_avg,
        input  o_avg_valid,
        input  o_level_high,
        input  o_event
    );

    // Monitor side.
    modport slave (
        input  i_adc_data,
        input  i_enable,
        output o_avg,
        output o_avg_valid,
        output o_level_high,
        output o_event
    );

endinterface

// File: rtl/adc_level_monitor_window_avg.sv
// Decimating sample timer plus fixed-window averager.
// The closing sample is folded into the average directly, so o_avg_valid
// rises in the cycle right after the capture of the last sample of a window.
module adc_window_avg
    import adc_mon_pkg::*;
#(
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int AVG_LOG2   = AVG_LOG2_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_adc_data,
    input  logic       i_enable,
    output logic [7:0] o_avg,
    output logic       o_avg_valid
);

    localparam int                TW       = $clog2(SAMPLE_DIV);
    localparam int                ACC_W    = 8 + AVG_LOG2;
    localparam logic [TW-1:0]     TC       = TW'(SAMPLE_DIV - 1);
    localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;

    logic [TW-1:0]       timer;
    logic [ACC_W-1:0]    acc;
    logic [AVG_LOG2-1:0] cnt;
    logic [ACC_W-1:0]    sum;

    // Running sum including the sample being captured this cycle.
    always_comb begin
        sum = acc + ACC_W'(i_adc_data);
    end

    // Timer, accumulation and window close; disabling discards the partial window.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            timer       <= '0;
            acc         <= '0;
            cnt         <= '0;
            o_avg       <= '0;
            o_avg_valid <= 1'b0;
        end else begin
            o_avg_valid <= 1'b0;
            if (!i_enable) begin
                timer <= '0;
                acc   <= '0;
                cnt   <= '0;
            end else if (timer == TC) begin
                timer <= '0;
                if (cnt == CNT_LAST) begin
                    o_avg       <= sum[ACC_W-1:AVG_LOG2];
                    o_avg_valid <= 1'b1;
                    acc         <= '0;
                    cnt         <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                end
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_level_monitor.sv
// Light/rain level monitor: window averager feeding a hysteresis + debounce FSM.
//
// state   | meaning
// LOW     | level low, waiting for an average >= TH_HIGH
// RISING  | counting consecutive high averages toward HOLD_CNT
// HIGH    | level high, waiting for an average <= TH_LOW
// FALLING | counting consecutive low averages toward HOLD_CNT
module adc_level_monitor
    import adc_mon_pkg::*;
#(
    parameter int         SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int         AVG_LOG2   = AVG_LOG2_DEF,
    parameter logic [7:0] TH_HIGH    = TH_HIGH_DEF,
    parameter logic [7:0] TH_LOW     = TH_LOW_DEF,
    parameter int         HOLD_CNT   = HOLD_CNT_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    adc_level_monitor_if.slave bus
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CNT);

    level_state_t state, state_nxt;
    logic [7:0]   hold, hold_nxt;
    logic         level_high, level_nxt;
    logic         event_q, event_nxt;
    logic [7:0]   avg;
    logic         avg_valid;

    adc_window_avg #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .AVG_LOG2   (AVG_LOG2)
    ) u_window (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_adc_data  (bus.i_adc_data),
        .i_enable    (bus.i_enable),
        .o_avg       (avg),
        .o_avg_valid (avg_valid)
    );

    assign bus.o_avg        = avg;
    assign bus.o_avg_valid  = avg_valid;
    assign bus.o_level_high = level_high;
    assign bus.o_event      = event_q;

    // State, hold count and registered level/event outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= LOW;
            hold       <= '0;
            level_high <= 1'b0;
            event_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold       <= hold_nxt;
            level_high <= level_nxt;
            event_q    <= event_nxt;
        end
    end

    // Next-state decode; only a fresh average can move the FSM.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        event_nxt = 1'b0;
        if (avg_valid) begin
            unique case (state)
                LOW: begin
                    if (avg >= TH_HIGH) begin
                        if (HOLD_LAST == 8'd1) begin
                            state_nxt = HIGH;
                            hold_nxt  = '0;
                            event_nxt = 1'b1;
                        end else begin
                            state_nxt = RISING;
                            hold_nxt  = 8'd1;
                        end
                    end
                end
                RISING: begin
                    if (avg >= TH_HIGH) begin
                        if (hold + 8'd1 == HOLD_LAST) begin
                            state_nxt = HIGH;
                            hold_nxt  = '0;
                            event_nxt = 1'b1;
                        end else begin
                            hold_nxt = hold + 8'd1;
                        end
                    end else begin
                        state_nxt = LOW;
                        hold_nxt  = '0;
                    end
                end
                HIGH: begin
                    if (avg <= TH_LOW) begin
                        if (HOLD_LAST == 8'd1) begin
                            state_nxt = LOW;
                            hold_nxt  = '0;
                            event_nxt = 1'b1;
                        end else begin
                            state_nxt = FALLING;
                            hold_nxt  = 8'd1;
                        end
                    end
                end
                FALLING: begin
                    if (avg <= TH_LOW) begin
                        if (hold + 8'd1 == HOLD_LAST) begin
                            state_nxt = LOW;
                            hold_nxt  = '0;
                            event_nxt = 1'b1;
                        end else begin
                            hold_nxt = hold + 8'd1;
                        end
                    end else begin
                        state_nxt = HIGH;
                        hold_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt = LOW;
                    hold_nxt  = '0;
                end
            endcase
        end
        level_nxt = (state_nxt == HIGH) || (state_nxt == FALLING);
    end

endmodule

// File: tb/tb_adc_level_monitor.sv
// Scoreboard bench: window tasks queue expected averages and FSM outcomes,
// a free-running monitor pops and compares whenever the DUT presents a result.
module tb_adc_level_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    adc_level_monitor_if bus ();

    adc_level_monitor #(
        .SAMPLE_DIV (4),
        .AVG_LOG2   (2),
        .TH_HIGH    (8'd180),
        .TH_LOW     (8'd120),
        .HOLD_CNT   (3)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] q_avg[$];
    logic [1:0] q_fsm[$];   // {level_high, event}

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One capture: data held for a full SAMPLE_DIV period, capture on its last edge.
    task automatic sample(input logic [7:0] d);
        bus.i_adc_data = d;
        repeat (4) @(negedge clk);
    endtask

    task automatic window(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3,
                          input logic [7:0] exp_avg, input logic exp_lvl,
                          input logic exp_evt);
        q_avg.push_back(exp_avg);
        q_fsm.push_back({exp_lvl, exp_evt});
        sample(d0);
        sample(d1);
        sample(d2);
        sample(d3);
    endtask

    task automatic const_window(input logic [7:0] d, input logic exp_lvl, input logic exp_evt);
        window(d, d, d, d, d, exp_lvl, exp_evt);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    int   cyc = 0;
    logic pend = 1'b0;
    logic first = 1'b1;
    always begin
        logic [7:0] ea;
        logic [1:0] ef;
        @(posedge clk);
        #1;
        if (rst) begin
            cyc   = 0;
            pend  = 1'b0;
            first = 1'b1;
        end else begin
            cyc++;
            if (pend) begin
                pend = 1'b0;
                if (q_fsm.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fsm_queue: got result with no expectation");
                end else begin
                    ef = q_fsm.pop_front();
                    check("level_high", int'(bus.o_level_high), int'(ef[1]));
                    check("event", int'(bus.o_event), int'(ef[0]));
                end
            end else if (bus.o_event) begin
                checks++;
                errors++;
                $display("FAIL stray_event: got 1 expected 0 at cycle %0d", cyc);
            end
            if (bus.o_avg_valid) begin
                if (first) check("first_valid_latency", cyc, 16);
                first = 1'b0;
                if (q_avg.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_avg_valid: got avg %0d expected none", bus.o_avg);
                end else begin
                    ea = q_avg.pop_front();
                    check("avg", int'(bus.o_avg), int'(ea));
                end
                pend = 1'b1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_adc_data = 8'd0;
        bus.i_enable   = 1'b0;
        rst            = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_avg", int'(bus.o_avg), 0);
        check("rst_avg_valid", int'(bus.o_avg_valid), 0);
        check("rst_level", int'(bus.o_level_high), 0);
        check("rst_event", int'(bus.o_event), 0);

        // Reset mid-window after one completed window.
        rst          = 1'b0;
        bus.i_enable = 1'b1;
        const_window(8'd100, 1'b0, 1'b0);
        sample(8'd100);
        sample(8'd100);
        rst = 1'b1;
        #2;
        check("midrun_rst_avg", int'(bus.o_avg), 0);
        check("midrun_rst_level", int'(bus.o_level_high), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Constant mid-band input.
        const_window(8'd100, 1'b0, 1'b0);
        const_window(8'd100, 1'b0, 1'b0);

        // Truncating average: 7 >> 2 = 1.
        window(8'd1, 8'd2, 8'd2, 8'd2, 8'd1, 1'b0, 1'b0);

        // Debounced rise then fall.
        const_window(8'd200, 1'b0, 1'b0);
        const_window(8'd200, 1'b0, 1'b0);
        const_window(8'd200, 1'b1, 1'b1);
        const_window(8'd100, 1'b1, 1'b0);
        const_window(8'd100, 1'b1, 1'b0);
        const_window(8'd100, 1'b0, 1'b1);

        // Interrupted rise, then exact-threshold rise.
        const_window(8'd200, 1'b0, 1'b0);
        const_window(8'd200, 1'b0, 1'b0);
        const_window(8'd150, 1'b0, 1'b0);
        const_window(8'd200, 1'b0, 1'b0);
        const_window(8'd150, 1'b0, 1'b0);
        const_window(8'd179, 1'b0, 1'b0);
        const_window(8'd180, 1'b0, 1'b0);
        const_window(8'd180, 1'b0, 1'b0);
        const_window(8'd180, 1'b1, 1'b1);

        // High side: mid-band holds, interrupted fall, exact-threshold fall.
        const_window(8'd150, 1'b1, 1'b0);
        const_window(8'd120, 1'b1, 1'b0);
        const_window(8'd121, 1'b1, 1'b0);
        const_window(8'd120, 1'b1, 1'b0);
        const_window(8'd120, 1'b1, 1'b0);
        const_window(8'd120, 1'b0, 1'b1);

        // Full-scale window, then enable drop discards a partial window.
        const_window(8'd255, 1'b0, 1'b0);
        sample(8'd250);
        sample(8'd250);
        bus.i_enable = 1'b0;
        repeat (10) @(negedge clk);
        bus.i_enable = 1'b1;
        const_window(8'd40, 1'b0, 1'b0);

        // Reset while RISING with hold=2 must leave no debounce credit behind.
        const_window(8'd200, 1'b0, 1'b0);
        const_window(8'd200, 1'b0, 1'b0);
        sample(8'd200);
        rst = 1'b1;
        #2;
        check("rising_rst_level", int'(bus.o_level_high), 0);
        check("rising_rst_event", int'(bus.o_event), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        const_window(8'd200, 1'b0, 1'b0);
        const_window(8'd200, 1'b0, 1'b0);
        const_window(8'd100, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        check("avg_queue_drained", q_avg.size(), 0);
        check("fsm_queue_drained", q_fsm.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
